scan_arbiter: RTL
=================

# scan_arbiter

Arbiter and sequencer for the shared XY2-100 galvo path. Grants the path to one of three scan-pattern generators at a time, round-robin. Issues the one-cycle start pulses that drive the scan multiplexer's `send_en`/`send_en2`/`send_en3` inputs, and drives its 2-bit source select. Between jobs it enforces transmitter drain and a galvo settle gap, and it aborts jobs that overrun a watchdog.

## Interface
- `SETTLE_CYCLES`, default 1000: idle gap between a release and the next grant; 0 = no gap.
- `TIMEOUT_CYCLES`, default 50_000_000: maximum RUN cycles per job; 0 = watchdog disabled.
- `CNT_W`, default 32: width of the settle and watchdog counters; both parameters must be < 2^CNT_W.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high.
- `req`  in  3  bit i: generator i requests the galvo path; level, held until done.
- `done`  in  3  bit i: one-cycle pulse, generator i finished its pattern.
- `xy2_busy`  in  1  XY2 transmitter still shifting a frame.
- `grant`  out  3  one-hot owner; 000 = none.
- `start`  out  3  one-cycle start pulse to the owner (feeds mux send_en/send_en2/send_en3).
- `select`  out  2  00 none, 01/10/11 = generator 0/1/2.
- `timeout`  out  1  one-cycle pulse on watchdog abort.
- `idle`  out  1  high only in IDLE.

## Operation
- FSM states: IDLE, RUN, DRAIN, SETTLE. All outputs are registered.
- Reset values: state IDLE; `grant` 000; `start` 000; `select` 00; `timeout` 0; `idle` 1; counters 0; round-robin pointer `last` = 2, so generator 0 wins first.
- IDLE, when `req` ≠ 0:
  - Winner w is the first set bit scanning `last`+1, `last`+2, `last` (mod 3).
  - Register `grant`[w], `select` = w+1, `start`[w] = 1, `last` = w. Go to RUN with the watchdog cleared.
- RUN:
  - `start` returns to 0 after its single cycle. The watchdog increments each cycle.
  - `done`[w] → DRAIN (normal end).
  - `req`[w] low without `done`[w] → DRAIN (abort).
  - Watchdog reaches TIMEOUT_CYCLES (nonzero) → `timeout` pulses 1 cycle, then DRAIN.
  - Priority when events coincide: `done` > `req` drop > timeout. A `timeout` pulse is never issued in the same cycle as an accepted `done`.
  - `done`/`req` changes from non-owners are ignored.
- DRAIN:
  - `grant`/`select` are held while `xy2_busy` = 1, so the in-flight frame is completed.
  - First cycle with `xy2_busy` = 0: `grant` ← 000, `select` ← 00. Go to SETTLE, or to IDLE when SETTLE_CYCLES = 0.
- SETTLE:
  - Counts SETTLE_CYCLES cycles with nothing granted, then goes to IDLE.
  - Requests are sampled only in IDLE, never during SETTLE.
- Counters saturate and never wrap. The watchdog is held at 0 outside RUN.
- `reset` asserted in any state: on the next edge everything returns to reset values, including `last`. An active `start` pulse is cut off.

## Timing
- `req` first high at edge k while in IDLE → `grant`, `select` and `start` all high in cycle k+1. `start` lasts exactly 1 cycle.
- `done` sampled at edge m, `xy2_busy` low → `grant` = 000 from cycle m+2. DRAIN takes one cycle; if `xy2_busy` is high it takes one extra cycle per busy cycle.
- Release to next grant: SETTLE_CYCLES + 2 cycles (SETTLE, IDLE, arbitration edge). With SETTLE_CYCLES = 0 it is 2 cycles.
- Timeout: `timeout` is high in the cycle after the watchdog equals TIMEOUT_CYCLES, which is also the first DRAIN cycle.
- `grant` is always one-hot or zero. `select` is always consistent with `grant`.

## Test plan
- Single job (SETTLE_CYCLES = 4): `req` = 001 at cycle 10 → `grant` = 001, `select` = 01, `start` = 001 at cycle 11 only. `done`[0] at cycle 30 → `grant` = 000 at 32, `idle` = 1 at 36.
- Round robin: `req` = 111 held, each job ends with `done` → grant order 001, 010, 100, 001, and exactly one `start` pulse per grant.
- Watchdog (TIMEOUT_CYCLES = 20): `req` = 010 with no `done` → single `timeout` pulse 20 cycles into RUN, followed by release. Coincident `done` and timeout → no `timeout` pulse.
- Drain: `done`[0] while `xy2_busy` stays high for 7 cycles → `grant` = 001 held through the busy window, released on the first cycle `xy2_busy` = 0.
- Abort and foreign events: owner drops `req` mid-RUN → DRAIN, no `timeout`. `done`[2] pulse while generator 0 owns → no effect.
- Reset mid-RUN: `reset` at RUN cycle 5 → next cycle `grant` = 000, `select` = 00, `idle` = 1. Subsequent `req` = 111 → generator 0 wins.

Source files
------------

// File: rtl/scan_arbiter.sv
// scan_arbiter: round-robin owner of the shared XY2-100 galvo path, sequencing
// start pulses, transmitter drain, galvo settle gap and a per-job watchdog.
module scan_arbiter #(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int CNT_W          = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [2:0] done,
    input  logic       xy2_busy,
    output logic [2:0] grant,
    output logic [2:0] start,
    output logic [1:0] select,
    output logic       timeout,
    output logic       idle
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, SETTLE} state_t;

    localparam logic [CNT_W-1:0] SETTLE_N  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_N = CNT_W'(TIMEOUT_CYCLES);

    state_t           state, nxt_state;
    logic [1:0]       last, nxt_last, p1, p2, win, nxt_select;
    logic [2:0]       nxt_grant, nxt_start;
    logic             nxt_timeout, done_hit, owner_req;
    logic [CNT_W-1:0] wd, nxt_wd, settle, nxt_settle;

    // Scan order last+1, last+2, then last itself.
    assign p1        = (last == 2'd2) ? 2'd0 : last + 2'd1;
    assign p2        = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
    assign win       = req[p1] ? p1 : req[p2] ? p2 : last;
    assign done_hit  = |(done & grant);
    assign owner_req = |(req & grant);

    always_comb begin
        nxt_state   = state;
        nxt_grant   = grant;
        nxt_select  = select;
        nxt_start   = 3'b000;
        nxt_timeout = 1'b0;
        nxt_last    = last;
        nxt_wd      = '0;
        nxt_settle  = '0;
        case (state)
            IDLE: if (|req) begin
                nxt_state  = RUN;
                nxt_grant  = 3'b001 << win;
                nxt_start  = 3'b001 << win;
                nxt_select = win + 2'd1;
                nxt_last   = win;
            end
            RUN: if (done_hit || !owner_req) begin
                nxt_state = DRAIN;
            end else if (TIMEOUT_N != '0 && wd == TIMEOUT_N) begin
                nxt_state   = DRAIN;
                nxt_timeout = 1'b1;
            end else begin
                nxt_wd = (&wd) ? wd : wd + 1'b1;
            end
            DRAIN: if (!xy2_busy) begin
                nxt_grant  = 3'b000;
                nxt_select = 2'b00;
                nxt_state  = (SETTLE_N == '0) ? IDLE : SETTLE;
            end
            SETTLE: if (settle == SETTLE_N - 1'b1) begin
                nxt_state = IDLE;
            end else begin
                nxt_settle = settle + 1'b1;
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= 3'b000;
            start   <= 3'b000;
            select  <= 2'b00;
            timeout <= 1'b0;
            idle    <= 1'b1;
            last    <= 2'd2;
            wd      <= '0;
            settle  <= '0;
        end else begin
            state   <= nxt_state;
            grant   <= nxt_grant;
            start   <= nxt_start;
            select  <= nxt_select;
            timeout <= nxt_timeout;
            idle    <= (nxt_state == IDLE);
            last    <= nxt_last;
            wd      <= nxt_wd;
            settle  <= nxt_settle;
        end
    end
endmodule
